// File: rtl/alu_decode_unit_pkg.sv
// Shared constants for the decode/ALU slice.
// Holds opcode encodings, instruction-class (aluop) codes and ALU operation codes.
package alu_decode_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned AOP_W  = 3;
  localparam int unsigned CODE_W = 6;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [AOP_W-1:0] AOP_R      = 3'b000;
  localparam logic [AOP_W-1:0] AOP_I      = 3'b001;
  localparam logic [AOP_W-1:0] AOP_BRANCH = 3'b010;
  localparam logic [AOP_W-1:0] AOP_JUMP   = 3'b011;
  localparam logic [AOP_W-1:0] AOP_LOAD   = 3'b100;
  localparam logic [AOP_W-1:0] AOP_STORE  = 3'b101;
  localparam logic [AOP_W-1:0] AOP_LUI    = 3'b110;
  localparam logic [AOP_W-1:0] AOP_AUIPC  = 3'b111;

  localparam logic [CODE_W-1:0] ALU_ADD   = 6'b000000;
  localparam logic [CODE_W-1:0] ALU_SUB   = 6'b001000;
  localparam logic [CODE_W-1:0] ALU_SLL   = 6'b000001;
  localparam logic [CODE_W-1:0] ALU_SLT   = 6'b000010;
  localparam logic [CODE_W-1:0] ALU_SLTU  = 6'b000011;
  localparam logic [CODE_W-1:0] ALU_XOR   = 6'b000100;
  localparam logic [CODE_W-1:0] ALU_SRL   = 6'b000101;
  localparam logic [CODE_W-1:0] ALU_SRA   = 6'b001101;
  localparam logic [CODE_W-1:0] ALU_OR    = 6'b000110;
  localparam logic [CODE_W-1:0] ALU_AND   = 6'b000111;
  localparam logic [CODE_W-1:0] ALU_BEQ   = 6'b010000;
  localparam logic [CODE_W-1:0] ALU_BNE   = 6'b010001;
  localparam logic [CODE_W-1:0] ALU_BLT   = 6'b010100;
  localparam logic [CODE_W-1:0] ALU_BGE   = 6'b010101;
  localparam logic [CODE_W-1:0] ALU_BLTU  = 6'b010110;
  localparam logic [CODE_W-1:0] ALU_BGEU  = 6'b010111;
  localparam logic [CODE_W-1:0] ALU_LINK  = 6'b011111;
  localparam logic [CODE_W-1:0] ALU_PASSB = 6'b100000;

endpackage

// File: rtl/alu.sv
// 32-bit datapath: arithmetic, logic, shifts, compares, branch decisions and link/pass-through.
module alu
  import alu_decode_unit_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;
  logic               eq;

  assign shamt = b[SHAMT_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign eq    = a == b;

  always_comb begin
    result = '0;
    case (code)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = XLEN'(lt_s);
      ALU_SLTU:  result = XLEN'(lt_u);
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_BEQ:   result = XLEN'(eq);
      ALU_BNE:   result = XLEN'(!eq);
      ALU_BLT:   result = XLEN'(lt_s);
      ALU_BGE:   result = XLEN'(!lt_s);
      ALU_BLTU:  result = XLEN'(lt_u);
      ALU_BGEU:  result = XLEN'(!lt_u);
      ALU_LINK:  result = a + XLEN'(4);
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// Maps instruction class plus funct fields to a 6-bit ALU operation code.
module alu_control
  import alu_decode_unit_pkg::*;
(
  input  logic [AOP_W-1:0]  aluop,
  input  logic              illegal,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = ALU_ADD;
    if (!illegal) begin
      case (aluop)
        AOP_R:      code = {2'b00, funct7_5, funct3};
        // Immediates only honour funct7[5] for the arithmetic right shift
        AOP_I:      code = {2'b00, (funct3 == 3'b101) & funct7_5, funct3};
        AOP_BRANCH: code = {3'b010, funct3};
        AOP_JUMP:   code = ALU_LINK;
        AOP_LUI:    code = ALU_PASSB;
        default:    code = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/controldecode.sv
// Opcode to control-signal decoder; flags unknown opcodes so the ALU code can fall back to ADD.
module controldecode
  import alu_decode_unit_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [AOP_W-1:0] aluop,
  output logic             regwrite,
  output logic             memwrite,
  output logic             memread,
  output logic             memtoreg,
  output logic             operandbsel,
  output logic             branch_o,
  output logic [1:0]       operandasel,
  output logic [1:0]       nextpcsel,
  output logic [1:0]       extendsel,
  output logic             illegal
);

  always_comb begin
    aluop       = AOP_R;
    regwrite    = 1'b0;
    memwrite    = 1'b0;
    memread     = 1'b0;
    memtoreg    = 1'b0;
    operandbsel = 1'b0;
    branch_o    = 1'b0;
    operandasel = 2'b00;
    nextpcsel   = 2'b00;
    extendsel   = 2'b00;
    illegal     = 1'b0;
    case (opcode)
      OPC_R: begin
        aluop    = AOP_R;
        regwrite = 1'b1;
      end
      OPC_I: begin
        aluop       = AOP_I;
        regwrite    = 1'b1;
        operandbsel = 1'b1;
      end
      OPC_LOAD: begin
        aluop       = AOP_LOAD;
        regwrite    = 1'b1;
        memread     = 1'b1;
        memtoreg    = 1'b1;
        operandbsel = 1'b1;
      end
      OPC_STORE: begin
        aluop       = AOP_STORE;
        memwrite    = 1'b1;
        operandbsel = 1'b1;
        extendsel   = 2'b01;
      end
      OPC_BRANCH: begin
        aluop     = AOP_BRANCH;
        branch_o  = 1'b1;
        nextpcsel = 2'b01;
      end
      OPC_JAL: begin
        aluop       = AOP_JUMP;
        regwrite    = 1'b1;
        operandasel = 2'b01;
        nextpcsel   = 2'b10;
      end
      OPC_JALR: begin
        aluop       = AOP_JUMP;
        regwrite    = 1'b1;
        operandasel = 2'b01;
        nextpcsel   = 2'b11;
      end
      OPC_LUI: begin
        aluop       = AOP_LUI;
        regwrite    = 1'b1;
        operandbsel = 1'b1;
        operandasel = 2'b11;
        extendsel   = 2'b10;
      end
      OPC_AUIPC: begin
        aluop       = AOP_AUIPC;
        regwrite    = 1'b1;
        operandbsel = 1'b1;
        operandasel = 2'b01;
        extendsel   = 2'b10;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_decode_unit.sv
// Top: combinational decode + ALU, with the ALU result also captured one cycle later.
module alu_decode_unit
  import alu_decode_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [XLEN-1:0]   operand_A,
  input  logic [XLEN-1:0]   operand_B,
  output logic              regwrite,
  output logic              memwrite,
  output logic              memread,
  output logic              memtoreg,
  output logic              operandbsel,
  output logic              branch_o,
  output logic [1:0]        operandasel,
  output logic [1:0]        nextpcsel,
  output logic [1:0]        extendsel,
  output logic [AOP_W-1:0]  aluop,
  output logic [CODE_W-1:0] ALU_Control,
  output logic [XLEN-1:0]   ALU_result,
  output logic [XLEN-1:0]   ALU_result_q
);

  logic illegal;
  logic unused_funct7;

  // Only funct7[5] distinguishes operations in this ISA subset
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  controldecode u_controldecode (
    .opcode      (opcode),
    .aluop       (aluop),
    .regwrite    (regwrite),
    .memwrite    (memwrite),
    .memread     (memread),
    .memtoreg    (memtoreg),
    .operandbsel (operandbsel),
    .branch_o    (branch_o),
    .operandasel (operandasel),
    .nextpcsel   (nextpcsel),
    .extendsel   (extendsel),
    .illegal     (illegal)
  );

  alu_control u_alu_control (
    .aluop    (aluop),
    .illegal  (illegal),
    .funct3   (funct3),
    .funct7_5 (funct7[5]),
    .code     (ALU_Control)
  );

  alu u_alu (
    .code   (ALU_Control),
    .a      (operand_A),
    .b      (operand_B),
    .result (ALU_result)
  );

  always_ff @(posedge clk) begin
    if (reset) ALU_result_q <= '0;
    else       ALU_result_q <= ALU_result;
  end

endmodule

// File: tb/tb_alu_decode_unit.sv
// Scoreboard bench for alu_decode_unit: directed vectors plus randomized instructions.
module tb_alu_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        regwrite, memwrite, memread, memtoreg, operandbsel, branch_o;
  logic [1:0]  operandasel, nextpcsel, extendsel;
  logic [2:0]  aluop;
  logic [5:0]  ALU_Control;
  logic [31:0] ALU_result;
  logic [31:0] ALU_result_q;

  typedef struct packed {
    logic [14:0] ctrl;
    logic [5:0]  code;
    logic [31:0] res;
    logic [31:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_decode_unit dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .operand_A    (operand_A),
    .operand_B    (operand_B),
    .regwrite     (regwrite),
    .memwrite     (memwrite),
    .memread      (memread),
    .memtoreg     (memtoreg),
    .operandbsel  (operandbsel),
    .branch_o     (branch_o),
    .operandasel  (operandasel),
    .nextpcsel    (nextpcsel),
    .extendsel    (extendsel),
    .aluop        (aluop),
    .ALU_Control  (ALU_Control),
    .ALU_result   (ALU_result),
    .ALU_result_q (ALU_result_q)
  );

  logic [14:0] ctrl_obs;
  assign ctrl_obs = {aluop, regwrite, memwrite, memread, memtoreg, operandbsel, branch_o,
                     operandasel, nextpcsel, extendsel};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (op=%07b f3=%03b A=%08h B=%08h)",
               tag, obs, exp, opcode, funct3, operand_A, operand_B);
    end
  endtask

  // {aluop, rw, mw, mr, m2r, bsel, br, asel, npc, ext}
  function automatic logic [14:0] ref_ctrl(input logic [6:0] op);
    case (op)
      7'b0110011: ref_ctrl = {3'b000, 6'b100000, 6'b000000};
      7'b0010011: ref_ctrl = {3'b001, 6'b100010, 6'b000000};
      7'b0000011: ref_ctrl = {3'b100, 6'b101110, 6'b000000};
      7'b0100011: ref_ctrl = {3'b101, 6'b010010, 6'b000001};
      7'b1100011: ref_ctrl = {3'b010, 6'b000001, 6'b000100};
      7'b1101111: ref_ctrl = {3'b011, 6'b100000, 6'b011000};
      7'b1100111: ref_ctrl = {3'b011, 6'b100000, 6'b011100};
      7'b0110111: ref_ctrl = {3'b110, 6'b100010, 6'b110010};
      7'b0010111: ref_ctrl = {3'b111, 6'b100010, 6'b010010};
      default:    ref_ctrl = 15'd0;
    endcase
  endfunction

  function automatic logic [5:0] ref_code(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
    case (op)
      7'b0110011: ref_code = {2'b00, f7[5], f3};
      7'b0010011: ref_code = {2'b00, (f3 == 3'd5) && f7[5], f3};
      7'b1100011: ref_code = {3'b010, f3};
      7'b1101111, 7'b1100111: ref_code = 6'b011111;
      7'b0110111: ref_code = 6'b100000;
      default:    ref_code = 6'b000000;
    endcase
  endfunction

  // Non-add/sub/shift-right register ops, selected by funct3
  function automatic logic [31:0] ref_misc(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd1: ref_misc = a << sh;
      3'd2: ref_misc = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: ref_misc = (a < b) ? 32'd1 : 32'd0;
      3'd4: ref_misc = a ^ b;
      3'd6: ref_misc = a | b;
      3'd7: ref_misc = a & b;
      default: ref_misc = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] sra;
    logic        alt;
    sh  = b[4:0];
    sra = $unsigned($signed(a) >>> sh);
    alt = f7[5];
    ref_result = 32'd0;
    case (op)
      7'b0110011: begin
        if (f3 == 3'd0)      ref_result = alt ? a - b : a + b;
        else if (f3 == 3'd5) ref_result = alt ? sra : a >> sh;
        else if (!alt)       ref_result = ref_misc(f3, a, b);
      end
      7'b0010011: begin
        if (f3 == 3'd0)      ref_result = a + b;
        else if (f3 == 3'd5) ref_result = alt ? sra : a >> sh;
        else                 ref_result = ref_misc(f3, a, b);
      end
      7'b1100011: begin
        case (f3)
          3'd0: ref_result = {31'd0, a == b};
          3'd1: ref_result = {31'd0, a != b};
          3'd4: ref_result = {31'd0, $signed(a) < $signed(b)};
          3'd5: ref_result = {31'd0, $signed(a) >= $signed(b)};
          3'd6: ref_result = {31'd0, a < b};
          3'd7: ref_result = {31'd0, a >= b};
          default: ref_result = 32'd0;
        endcase
      end
      7'b1101111, 7'b1100111: ref_result = a + 32'd4;
      7'b0110111: ref_result = b;
      default:    ref_result = a + b;
    endcase
  endfunction

  // Apply one vector and push its expectations
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic rst);
    exp_t e;
    opcode    = op;
    funct3    = f3;
    funct7    = f7;
    operand_A = a;
    operand_B = b;
    reset     = rst;
    e.ctrl = ref_ctrl(op);
    e.code = ref_code(op, f3, f7);
    e.res  = ref_result(op, f3, f7, a, b);
    e.q    = rst ? 32'd0 : e.res;
    sb.push_back(e);
    #2;
  endtask

  // Pop expectation, compare combinational outputs, clock, compare registered output
  task automatic retire();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("ctrl", 32'(ctrl_obs), 32'(e.ctrl));
      check("alu_control", 32'(ALU_Control), 32'(e.code));
      check("alu_result", ALU_result, e.res);
      @(posedge clk);
      #1;
      check("alu_result_q", ALU_result_q, e.q);
    end
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    reset = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; operand_A = '0; operand_B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", ALU_result_q, 32'd0);

    drive(7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7, 1'b0);
    check("sub_code", 32'(ALU_Control), 32'h08);
    check("sub_res", ALU_result, 32'hFFFF_FFFE);
    check("sub_rw", 32'(regwrite), 32'd1);
    retire();

    drive(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 1'b0);
    check("srai_code", 32'(ALU_Control), 32'h0D);
    check("srai_res", ALU_result, 32'hF800_0000);
    retire();

    drive(7'b1100011, 3'b100, 7'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("blt_code", 32'(ALU_Control), 32'h14);
    check("blt_res", ALU_result, 32'd1);
    check("blt_br", 32'(branch_o), 32'd1);
    check("blt_npc", 32'(nextpcsel), 32'd1);
    retire();

    drive(7'b1100011, 3'b110, 7'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("bltu_res", ALU_result, 32'd0);
    retire();

    drive(7'b0100011, 3'b010, 7'd0, 32'h100, 32'h8, 1'b0);
    check("sw_mw", 32'(memwrite), 32'd1);
    check("sw_rw", 32'(regwrite), 32'd0);
    check("sw_ext", 32'(extendsel), 32'd1);
    check("sw_res", ALU_result, 32'h108);
    retire();

    drive(7'b0110111, 3'b000, 7'd0, 32'hDEAD_BEEF, 32'h1234_5000, 1'b0);
    check("lui_res", ALU_result, 32'h1234_5000);
    retire();

    drive(7'b1111111, 3'b000, 7'd0, 32'd1, 32'd2, 1'b0);
    check("bad_ctrl", 32'(ctrl_obs), 32'd0);
    check("bad_code", 32'(ALU_Control), 32'd0);
    check("bad_res", ALU_result, 32'd3);
    retire();

    // Reset dominates: 3 captured, then reset clears while result is 9, then 9 captured
    drive(7'b0110111, 3'b000, 7'd0, 32'd0, 32'd3, 1'b0);
    retire();
    drive(7'b0110111, 3'b000, 7'd0, 32'd0, 32'd9, 1'b1);
    retire();
    drive(7'b0110111, 3'b000, 7'd0, 32'd0, 32'd9, 1'b0);
    retire();

    for (int i = 0; i < 200; i++) begin
      drive(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000,
            (i % 5 == 0) ? 32'h8000_0000 : $urandom(),
            (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom(),
            ($urandom_range(0, 15) == 0));
      retire();
    end

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
